// File: rtl/queue_dispatcher.sv
// Pops the arbiter-granted queue, buffers returned words (2 entries) onto a valid/ready port; pop-to-valid 2 cycles.
// Backpressure: rr_enb/pop drop when buffer plus in-flight word would exceed 2. DISPATCH_STATS_EN adds per-queue pop counters.
module queue_dispatcher #(
   parameter int QUEUE_QUANTITY = 4,
   parameter int DATA_BITS      = 8
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                enb,
   input  logic [$clog2(QUEUE_QUANTITY)-1:0]   selector,
   input  logic                                selector_enb,
   input  logic [QUEUE_QUANTITY-1:0]           buf_empty,
   input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] buf_data,
   output logic [QUEUE_QUANTITY-1:0]           pop,
   output logic                                rr_enb,
   output logic [DATA_BITS-1:0]                data_out,
   output logic                                valid_out,
   input  logic                                ready_in,
   output logic                                err_empty,
   output logic [QUEUE_QUANTITY*16-1:0]        served_count
);
   localparam int SEL_W = $clog2(QUEUE_QUANTITY);

   logic [1:0]           count_q, count_d;
   logic                 inflight_q;
   logic [SEL_W-1:0]     inflight_idx_q;
   logic                 head_q, tail_q;
   logic [DATA_BITS-1:0] mem_q [2];
   logic                 err_empty_q;

   logic                 fire, space, do_pop, empty_grant;
   logic [2:0]           occ;
   logic [DATA_BITS-1:0] lane [QUEUE_QUANTITY];

   always_comb begin
      for (int i = 0; i < QUEUE_QUANTITY; i++) begin
         lane[i] = buf_data[i*DATA_BITS +: DATA_BITS];
      end
   end

   assign valid_out = (count_q != 2'd0);
   assign fire      = valid_out & ready_in;
   // The in-flight word has already been promised a slot, so it counts as occupancy.
   assign occ       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, fire};
   assign space     = (occ < 3'd2);
   assign rr_enb    = enb & space & rst;
   assign do_pop    = rr_enb & selector_enb & ~buf_empty[selector];
   assign empty_grant = rr_enb & selector_enb & buf_empty[selector];
   assign pop       = do_pop ? ({{(QUEUE_QUANTITY-1){1'b0}}, 1'b1} << selector) : '0;
   assign data_out  = valid_out ? mem_q[head_q] : '0;
   assign err_empty = err_empty_q;

   always_comb begin
      count_d = count_q;
      case ({inflight_q, fire})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q        <= 2'd0;
         inflight_q     <= 1'b0;
         inflight_idx_q <= '0;
         head_q         <= 1'b0;
         tail_q         <= 1'b0;
         err_empty_q    <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         inflight_q     <= do_pop;
         inflight_idx_q <= selector;
         count_q        <= count_d;
         if (inflight_q) begin
            mem_q[tail_q] <= lane[inflight_idx_q];
            tail_q        <= ~tail_q;
         end
         if (fire) begin
            head_q <= ~head_q;
         end
         if (empty_grant) begin
            err_empty_q <= 1'b1;
         end
      end
   end

`ifdef DISPATCH_STATS_EN
   logic [15:0] served_q [QUEUE_QUANTITY];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < QUEUE_QUANTITY; i++) begin
            served_q[i] <= 16'd0;
         end
      end else begin
         for (int i = 0; i < QUEUE_QUANTITY; i++) begin
            if (pop[i]) begin
               served_q[i] <= served_q[i] + 16'd1;
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < QUEUE_QUANTITY; i++) begin
         served_count[i*16 +: 16] = served_q[i];
      end
   end
`else
   assign served_count = '0;
`endif

endmodule

// File: tb/tb_queue_dispatcher.sv
// Directed bench for queue_dispatcher: reset, single word, backpressure, streaming, empty grant, stats.
module tb_queue_dispatcher;
   logic        clk;
   logic        rst;
   logic        enb;
   logic [1:0]  selector;
   logic        selector_enb;
   logic [3:0]  buf_empty;
   logic [31:0] buf_data;
   logic [3:0]  pop;
   logic        rr_enb;
   logic [7:0]  data_out;
   logic        valid_out;
   logic        ready_in;
   logic        err_empty;
   logic [63:0] served_count;

   int checks;
   int errors;

   queue_dispatcher #(.QUEUE_QUANTITY(4), .DATA_BITS(8)) dut (
      .clk(clk), .rst(rst), .enb(enb), .selector(selector), .selector_enb(selector_enb),
      .buf_empty(buf_empty), .buf_data(buf_data), .pop(pop), .rr_enb(rr_enb),
      .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
      .err_empty(err_empty), .served_count(served_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset valid_out: got %b want 0", valid_out); end
      checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset data_out: got %h want 00", data_out); end
      checks++; if (pop !== 4'b0000) begin errors++; $display("FAIL reset pop: got %b want 0000", pop); end
      checks++; if (rr_enb !== 1'b0) begin errors++; $display("FAIL reset rr_enb: got %b want 0", rr_enb); end
      checks++; if (err_empty !== 1'b0) begin errors++; $display("FAIL reset err_empty: got %b want 0", err_empty); end
      checks++; if (served_count !== 64'd0) begin errors++; $display("FAIL reset served_count: got %h want 0", served_count); end
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_single_word();
      enb = 1'b1; ready_in = 1'b1; buf_empty = 4'b1011; selector = 2'd2; selector_enb = 1'b1;
      #1;
      checks++; if (pop !== 4'b0100) begin errors++; $display("FAIL single pop N: got %b want 0100", pop); end
      tick();
      selector_enb = 1'b0; buf_data = 32'h00A5_0000;
      #1;
      checks++; if (valid_out !== 1'b0 || pop !== 4'b0000) begin errors++; $display("FAIL single N+1: got valid %b pop %b want 0 0000", valid_out, pop); end
      tick();
      checks++; if (valid_out !== 1'b1 || data_out !== 8'hA5) begin errors++; $display("FAIL single N+2: got valid %b data %h want 1 a5", valid_out, data_out); end
      tick();
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL single N+3: got valid %b want 0", valid_out); end
   endtask

   task automatic test_backpressure();
      logic [3:0] exp_pop [9];
      logic       exp_rr  [9];
      logic       exp_vld [9];
      logic [7:0] exp_dat [9];
      exp_pop = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
      exp_rr  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      exp_vld = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      exp_dat = '{8'h00, 8'h00, 8'h10, 8'h10, 8'h10, 8'h11, 8'h12, 8'h13, 8'h00};
      buf_empty = 4'b0000; buf_data = 32'h1312_1110; ready_in = 1'b0;
      for (int k = 0; k < 9; k++) begin
         selector_enb = (k < 6);
         selector     = (k < 2) ? 2'(k) : (k < 5) ? 2'd2 : 2'd3;
         ready_in     = (k >= 4);
         #1;
         checks++; if (pop !== exp_pop[k] || rr_enb !== exp_rr[k]) begin errors++; $display("FAIL backpressure cycle %0d: got pop %b rr_enb %b want %b %b", k, pop, rr_enb, exp_pop[k], exp_rr[k]); end
         checks++; if (valid_out !== exp_vld[k] || data_out !== exp_dat[k]) begin errors++; $display("FAIL backpressure out cycle %0d: got valid %b data %h want %b %h", k, valid_out, data_out, exp_vld[k], exp_dat[k]); end
         tick();
      end
   endtask

   task automatic test_streaming();
      logic [7:0] words [8];
      words = '{8'h20, 8'h30, 8'h40, 8'h50, 8'h21, 8'h31, 8'h41, 8'h51};
      buf_empty = 4'b0000; ready_in = 1'b1;
      for (int k = 0; k < 11; k++) begin
         selector_enb = (k < 8);
         selector     = 2'(k % 4);
         if (k >= 1 && k <= 8) buf_data = {4{words[k-1]}};
         #1;
         if (k < 8) begin
            checks++; if (pop !== (4'b0001 << (k % 4))) begin errors++; $display("FAIL stream pop cycle %0d: got %b want %b", k, pop, 4'b0001 << (k % 4)); end
         end
         if (k >= 2 && k <= 9) begin
            checks++; if (valid_out !== 1'b1 || data_out !== words[k-2]) begin errors++; $display("FAIL stream out cycle %0d: got valid %b data %h want 1 %h", k, valid_out, data_out, words[k-2]); end
         end else begin
            checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL stream idle cycle %0d: got valid %b want 0", k, valid_out); end
         end
         tick();
      end
   endtask

   task automatic test_empty_grant();
      buf_empty = 4'b0010; selector = 2'd1; selector_enb = 1'b1; ready_in = 1'b1;
      #1;
      checks++; if (pop !== 4'b0000) begin errors++; $display("FAIL empty grant pop: got %b want 0000", pop); end
      checks++; if (err_empty !== 1'b0) begin errors++; $display("FAIL empty grant err before edge: got %b want 0", err_empty); end
      tick();
      selector_enb = 1'b0; buf_empty = 4'b0000;
      #1;
      checks++; if (err_empty !== 1'b1) begin errors++; $display("FAIL empty grant err set: got %b want 1", err_empty); end
      repeat (3) tick();
      checks++; if (err_empty !== 1'b1) begin errors++; $display("FAIL empty grant err sticky: got %b want 1", err_empty); end
   endtask

   task automatic test_reset_midstream();
      buf_empty = 4'b0000; buf_data = 32'h7777_7777; selector = 2'd0; selector_enb = 1'b1; ready_in = 1'b0;
      repeat (3) tick();
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL midreset fill: got valid %b want 1", valid_out); end
      rst = 1'b0;
      #1;
      checks++; if (valid_out !== 1'b0 || data_out !== 8'h00) begin errors++; $display("FAIL midreset out: got valid %b data %h want 0 00", valid_out, data_out); end
      checks++; if (pop !== 4'b0000 || rr_enb !== 1'b0) begin errors++; $display("FAIL midreset pop: got pop %b rr_enb %b want 0000 0", pop, rr_enb); end
      checks++; if (err_empty !== 1'b0) begin errors++; $display("FAIL midreset err_empty: got %b want 0", err_empty); end
      selector_enb = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      selector = 2'd1; selector_enb = 1'b1; ready_in = 1'b1; buf_data = 32'h3C3C_3C3C;
      #1;
      checks++; if (pop !== 4'b0010) begin errors++; $display("FAIL post reset pop: got %b want 0010", pop); end
      tick();
      selector_enb = 1'b0;
      #1;
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL post reset N+1: got valid %b want 0", valid_out); end
      tick();
      checks++; if (valid_out !== 1'b1 || data_out !== 8'h3C) begin errors++; $display("FAIL post reset N+2: got valid %b data %h want 1 3c", valid_out, data_out); end
      tick();
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL post reset drain: got valid %b want 0", valid_out); end
   endtask

   task automatic test_stats();
`ifdef DISPATCH_STATS_EN
      buf_empty = 4'b0000; selector = 2'd3; selector_enb = 1'b1; ready_in = 1'b1;
      repeat (3) tick();
      selector_enb = 1'b0;
      #1;
      checks++; if (served_count !== {16'd3, 48'd0}) begin errors++; $display("FAIL stats three pops: got %h want 0003000000000000", served_count); end
      selector_enb = 1'b1;
      repeat (65533) tick();
      selector_enb = 1'b0;
      #1;
      checks++; if (served_count !== 64'd0) begin errors++; $display("FAIL stats wrap: got %h want 0", served_count); end
      repeat (3) tick();
`else
      checks++; if (served_count !== 64'd0) begin errors++; $display("FAIL stats disabled: got %h want 0", served_count); end
`endif
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b0; enb = 1'b0; selector = 2'd0; selector_enb = 1'b0;
      buf_empty = 4'b1111; buf_data = 32'd0; ready_in = 1'b0;
      test_reset();
      test_single_word();
      test_backpressure();
      test_streaming();
      test_stats();
      test_empty_grant();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end
endmodule
